// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
//   N_REQ / SEL_W : requester count and select width
//   arb_state_t   : arbiter FSM states
//   onehot8()     : binary index -> one-hot grant vector
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority encoder.
//   req[7:0]  in  : request levels
//   ptr[2:0]  in  : index with top priority; the scan runs upward from here, mod 8
//   excl[7:0] in  : requests to ignore for this scan
//   idx[2:0]  out : first unmasked requester found at or after ptr
//   found     out : high when any unmasked request exists
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [N_REQ-1:0] masked;
  logic [SEL_W-1:0] cand [N_REQ];

  assign masked = req & ~excl;

  // cand[k] is the requester at scan position k; the 3-bit add wraps 7+1 to 0.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand[gi] = ptr + SEL_W'(gi);
  end

  // Walk from the farthest position down so the nearest hit overwrites the rest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (masked[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 single-bit mux.
//   MAX_BURST      : max consecutive grant cycles while others wait (2..16)
//   clk            in  : clock, rising edge
//   rst_n          in  : asynchronous active-low reset
//   req[7:0]       in  : level request per mux input
//   gnt[7:0]       out : registered one-hot grant, zero when idle
//   sel[2:0]       out : registered owner index, wired to mux S
//   busy           out : registered, high while a grant is held
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam int                 CNT_W    = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [SEL_W-1:0] ptr_reg,   ptr_next;
  logic [N_REQ-1:0] gnt_reg,   gnt_next;
  logic [SEL_W-1:0] sel_reg,   sel_next;
  logic             busy_reg,  busy_next;

  logic             owner_req;
  logic             others_pending;
  logic             burst_expire;
  logic [N_REQ-1:0] pick_excl;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             take_new;

  assign owner_req      = req[sel_reg];
  assign others_pending = |(req & ~gnt_reg);
  assign burst_expire   = (state_reg == GRANT) && owner_req &&
                          (cnt_reg == CNT_LAST) && others_pending;

  // On burst expiry the owner's still-high request must not win again;
  // on release its request is already low, so no mask is needed.
  assign pick_excl = burst_expire ? gnt_reg : '0;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .excl  (pick_excl),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    busy_next  = busy_reg;
    take_new   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_found) take_new = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          if (pick_found) begin
            take_new = 1'b1;          // zero-bubble handoff on release
          end else begin
            state_next = IDLE;        // sel deliberately keeps its last value
            gnt_next   = '0;
            busy_next  = 1'b0;
          end
        end else if (burst_expire) begin
          take_new = 1'b1;
        end else if (cnt_reg != CNT_LAST) begin
          cnt_next = cnt_reg + 1'b1;  // saturates so a lone owner holds forever
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase

    if (take_new) begin
      state_next = GRANT;
      gnt_next   = onehot8(pick_idx);
      sel_next   = pick_idx;
      busy_next  = 1'b1;
      cnt_next   = '0;
      ptr_next   = pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
    end
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [11:0] exp;   // {gnt, sel, busy}
  } sb_t;

  sb_t sb[$];

  mux8_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed gnt=%h sel=%0d busy=%b expected gnt=%h sel=%0d busy=%b",
             tag, obs[11:4], obs[3:1], obs[0], exp[11:4], exp[3:1], exp[0]);
    end
    $display("chk %-14s gnt=%h sel=%0d busy=%b", tag, obs[11:4], obs[3:1], obs[0]);
  endtask

  // One clock transaction: drive req on the falling edge, queue the expected
  // outputs, then pop and compare just after the next rising edge.
  task automatic step(input logic [7:0] r, input logic [7:0] eg, input logic [2:0] es,
                      input logic eb, input string tag);
    sb_t e;
    @(negedge clk);
    req = r;
    sb.push_back('{tag, {eg, es, eb}});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, {gnt, sel, busy}, e.exp);
  endtask

  // Asynchronous reset pulse issued mid-cycle, checked before the next edge.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    check(tag, {gnt, sel, busy}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] own;

    // Reset and idle
    #2;
    check("rst_async", {gnt, sel, busy}, 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 3'd0, 1'b0, "idle");

    // Single requester holds without limit, then releases
    step(8'h08, 8'h08, 3'd3, 1'b1, "single_grant");
    for (int i = 0; i < 20; i++) step(8'h08, 8'h08, 3'd3, 1'b1, "single_hold");
    step(8'h00, 8'h00, 3'd3, 1'b0, "single_rel");

    // Full contention from reset priority: 0..7 then wrap to 0, 4 cycles each
    reset_pulse("rst_pre_ff");
    step(8'h00, 8'h00, 3'd0, 1'b0, "idle_ff");
    for (int c = 0; c < 36; c++) begin
      own = 3'((c / 4) % 8);
      step(8'hFF, 8'h01 << own, own, 1'b1, (c >= 32) ? "ff_wrap" : "ff_rr");
    end
    step(8'h00, 8'h00, 3'd0, 1'b0, "ff_rel");

    // 0x81: owner 7 releases after two cycles, handoff to 0 with busy kept high
    step(8'h81, 8'h80, 3'd7, 1'b1, "h81_g7");
    step(8'h81, 8'h80, 3'd7, 1'b1, "h81_hold7");
    step(8'h01, 8'h01, 3'd0, 1'b1, "h81_hand0");
    step(8'h01, 8'h01, 3'd0, 1'b1, "h81_hold0");
    step(8'h01, 8'h01, 3'd0, 1'b1, "h81_hold0");
    step(8'h00, 8'h00, 3'd0, 1'b0, "h81_idle");

    // Fairness: a grant to 4 leaves ptr at 5; then 0x24 alternates 5,2,5
    step(8'h10, 8'h10, 3'd4, 1'b1, "fair_g4");
    step(8'h24, 8'h20, 3'd5, 1'b1, "fair_g5");
    for (int i = 0; i < 3; i++) step(8'h24, 8'h20, 3'd5, 1'b1, "fair_hold5");
    step(8'h24, 8'h04, 3'd2, 1'b1, "fair_exp2");
    for (int i = 0; i < 3; i++) step(8'h24, 8'h04, 3'd2, 1'b1, "fair_hold2");
    step(8'h24, 8'h20, 3'd5, 1'b1, "fair_back5");

    // Reset mid-grant while sel = 6, then 0x41 goes to requester 0
    step(8'h40, 8'h40, 3'd6, 1'b1, "pre_rst_g6");
    step(8'h40, 8'h40, 3'd6, 1'b1, "pre_rst_hold6");
    reset_pulse("rst_mid");
    step(8'h00, 8'h00, 3'd0, 1'b0, "post_rst_idle");
    step(8'h41, 8'h01, 3'd0, 1'b1, "post_rst_g0");
    step(8'h00, 8'h00, 3'd0, 1'b0, "post_rst_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
